// File: rtl/bus_pkg.sv
// Shared bus definitions: transfer mode encoding, data width and the
// memory responder's state encoding.
package bus_pkg;

  localparam int BUS_DATA_WIDTH = 32;

  // Transfer mode as driven on BUS_mode by the control unit.
  localparam logic BUS_MODE_READ  = 1'b0;
  localparam logic BUS_MODE_WRITE = 1'b1;

  // Wait-state counter width; covers the legal 0..15 range.
  localparam int WAIT_CNT_WIDTH = 4;

  // Responder FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

endpackage

// File: rtl/bus_mem_array.sv
// Word-addressed RAM behind the bus responder: one address port, synchronous
// write, combinational read.
module bus_mem_array
  import bus_pkg::*;
#(
  parameter int    ADDR_WIDTH = 8,
  parameter string INIT_FILE  = ""
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [BUS_DATA_WIDTH-1:0] wdata,
  output logic [BUS_DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [BUS_DATA_WIDTH-1:0] mem [DEPTH];

  // Commit a write word at the clock edge.
  // NOTE: the array has no reset; its contents survive rst and clearing it would force a flop-based implementation.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side bus responder: accepts one request at a time, inserts
// WAIT_CYCLES wait states, then pulses the read or write completion for one
// cycle. Out-of-range addresses complete normally but also raise BUS_err.
module bus_mem_responder
  import bus_pkg::*;
#(
  parameter int    ADDR_WIDTH  = 8,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        BUS_start_transaction,
  input  logic        BUS_mode,
  input  logic [31:0] BUS_addr,
  input  logic [31:0] BUS_wdata,
  output logic [31:0] BUS_rdata,
  output logic        BUS_rdata_valid,
  output logic        BUS_write_done,
  output logic        BUS_err,
  output logic        busy
);

  localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD = WAIT_CNT_WIDTH'(WAIT_CYCLES);

  resp_state_t                state_q, state_d;
  logic [WAIT_CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                       mode_q, mode_d;
  logic [31:0]                addr_q, addr_d;
  logic [31:0]                wdata_q, wdata_d;
  logic                       oor_q, oor_d;
  logic                       mem_we;
  logic [31:0]                mem_rdata;
  logic                       resp_next;
  logic                       unused_byte_lane;

  // Any address bit above the array's reach makes the request out of range.
  assign oor_q = |addr_q[31:ADDR_WIDTH+2];
  assign oor_d = |addr_d[31:ADDR_WIDTH+2];

  // Byte-lane bits select nothing: accesses are whole words.
  assign unused_byte_lane = ^addr_d[1:0];

  // A write lands at the edge that ends RESP, unless reset kills it there.
  assign mem_we = (state_q == RESP) && (mode_q == BUS_MODE_WRITE) && !oor_q && !rst;

  assign resp_next = (state_d == RESP);

  // The array address follows the request that is about to be responded to;
  // during a write's RESP cycle this equals addr_q, so one port suffices.
  bus_mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (addr_d[ADDR_WIDTH+1:2]),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  // Next-state and request-capture decode.
  // NOTE: every signal gets a default before the case so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (BUS_start_transaction) begin
          mode_d  = BUS_mode;
          addr_d  = BUS_addr;
          wdata_d = BUS_wdata;
          cnt_d   = WAIT_LOAD;
          state_d = (WAIT_LOAD == '0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, request registers and registered outputs, all set up one edge
  // ahead so the response flags are high exactly while the FSM is in RESP.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      mode_q          <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      busy            <= 1'b0;
      BUS_rdata_valid <= 1'b0;
      BUS_write_done  <= 1'b0;
      BUS_err         <= 1'b0;
      BUS_rdata       <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      mode_q          <= mode_d;
      addr_q          <= addr_d;
      wdata_q         <= wdata_d;
      busy            <= (state_d != IDLE);
      BUS_rdata_valid <= resp_next && (mode_d == BUS_MODE_READ);
      BUS_write_done  <= resp_next && (mode_d == BUS_MODE_WRITE);
      BUS_err         <= resp_next && oor_d;
      BUS_rdata       <= (resp_next && (mode_d == BUS_MODE_READ) && !oor_d) ? mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: a default build (2 wait states) and a
// zero-wait build run side by side; expected completions are queued when a
// request is strobed and compared when the completion pulse appears.
module tb_bus_mem_responder;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;
  localparam int   WAITS_A = 2;
  localparam int   WAITS_B = 0;

  typedef struct {
    logic        is_read;
    logic [31:0] data;
    logic        err;
    int          lat;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start  [2];
  logic        mode   [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic [31:0] rdata  [2];
  logic        rvalid [2];
  logic        wdone  [2];
  logic        err    [2];
  logic        busy   [2];

  sb_t sb[$];
  int  compared   = 0;
  int  mismatched = 0;
  int  cyc        = 0;

  bus_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(WAITS_A), .INIT_FILE("")) dut_a (
    .clk(clk), .rst(rst),
    .BUS_start_transaction(start[0]), .BUS_mode(mode[0]),
    .BUS_addr(addr[0]), .BUS_wdata(wdata[0]),
    .BUS_rdata(rdata[0]), .BUS_rdata_valid(rvalid[0]),
    .BUS_write_done(wdone[0]), .BUS_err(err[0]), .busy(busy[0])
  );

  bus_mem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(WAITS_B), .INIT_FILE("")) dut_b (
    .clk(clk), .rst(rst),
    .BUS_start_transaction(start[1]), .BUS_mode(mode[1]),
    .BUS_addr(addr[1]), .BUS_wdata(wdata[1]),
    .BUS_rdata(rdata[1]), .BUS_rdata_valid(rvalid[1]),
    .BUS_write_done(wdone[1]), .BUS_err(err[1]), .busy(busy[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int s);
    return (s == 0) ? WAITS_A + 1 : WAITS_B + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle strobe from the current falling edge; inputs go to X
  // afterwards since they must not matter while the strobe is low.
  task automatic strobe(input int s, input logic m, input logic [31:0] a, input logic [31:0] d);
    start[s] = 1'b1;
    mode[s]  = m;
    addr[s]  = a;
    wdata[s] = d;
    @(negedge clk);
    start[s] = 1'b0;
    mode[s]  = 1'bx;
    addr[s]  = 'x;
    wdata[s] = 'x;
  endtask

  task automatic issue(input int s, input logic m, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_data, input logic exp_err);
    sb.push_back('{is_read: (m == RD), data: exp_data, err: exp_err, lat: lat_of(s)});
    strobe(s, m, a, d);
  endtask

  // Walk cycles after a strobe until a completion pulse, checking the idle
  // cycles before it and the cycle after it; bounded by a cycle budget.
  task automatic await_done(input int s, input string tag, output int when);
    sb_t e;
    bit  seen;
    seen = 1'b0;
    when = -1;
    for (int k = 1; k <= 20 && !seen; k++) begin
      if (rvalid[s] === 1'b1 || wdone[s] === 1'b1) begin
        seen = 1'b1;
        when = cyc;
        if (sb.size() == 0) begin
          check({tag, " unexpected pulse"}, {31'b0, rvalid[s] | wdone[s]}, 32'd0);
        end else begin
          e = sb.pop_front();
          check({tag, " latency"}, k, e.lat);
          check({tag, " rdata_valid"}, {31'b0, rvalid[s]}, {31'b0, e.is_read});
          check({tag, " write_done"}, {31'b0, wdone[s]}, {31'b0, !e.is_read});
          check({tag, " err"}, {31'b0, err[s]}, {31'b0, e.err});
          check({tag, " rdata"}, rdata[s], e.data);
          check({tag, " busy in resp"}, {31'b0, busy[s]}, 32'd1);
        end
      end else begin
        check({tag, " rdata idle"}, rdata[s], 32'd0);
        check({tag, " busy wait"}, {31'b0, busy[s]}, 32'd1);
      end
      @(negedge clk);
    end
    check({tag, " completed"}, {31'b0, seen}, 32'd1);
    if (seen) begin
      check({tag, " busy after"}, {31'b0, busy[s]}, 32'd0);
      check({tag, " single pulse"}, {30'b0, rvalid[s], wdone[s]}, 32'd0);
    end
  endtask

  task automatic quiet(input int s, input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      check({tag, " no pulse"}, {30'b0, rvalid[s], wdone[s]}, 32'd0);
      check({tag, " idle"}, {31'b0, busy[s]}, 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    int  t0, t1, t2;
    sb_t e;

    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      start[s] = 1'b0; mode[s] = RD; addr[s] = '0; wdata[s] = '0;
    end
    repeat (3) @(negedge clk);

    // Reset state of both builds.
    for (int s = 0; s < 2; s++) begin
      check("reset busy", {31'b0, busy[s]}, 32'd0);
      check("reset pulses", {29'b0, rvalid[s], wdone[s], err[s]}, 32'd0);
      check("reset rdata", rdata[s], 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Write then two reads of the same word through different byte offsets.
    issue(0, WR, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, 1'b0);
    await_done(0, "wr 0x10", t0);
    issue(0, RD, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0);
    await_done(0, "rd 0x10", t0);
    issue(0, RD, 32'h0000_0013, 32'd0, 32'hDEAD_BEEF, 1'b0);
    await_done(0, "rd 0x13", t0);

    // Strobes during WAIT and during RESP of a read must be dropped.
    sb.push_back('{is_read: 1'b1, data: 32'hDEAD_BEEF, err: 1'b0, lat: lat_of(0)});
    strobe(0, RD, 32'h0000_0010, 32'd0);
    start[0] = 1'b1; mode[0] = WR; addr[0] = 32'h0000_0010; wdata[0] = 32'h0;
    @(negedge clk);
    start[0] = 1'b0; mode[0] = 1'bx; addr[0] = 'x; wdata[0] = 'x;
    check("busy strobe wait", {31'b0, busy[0]}, 32'd1);
    check("no pulse wait", {30'b0, rvalid[0], wdone[0]}, 32'd0);
    @(negedge clk);
    e = sb.pop_front();
    check("busy strobe resp rvalid", {31'b0, rvalid[0]}, {31'b0, e.is_read});
    check("busy strobe resp rdata", rdata[0], e.data);
    start[0] = 1'b1; mode[0] = WR; addr[0] = 32'h0000_0010; wdata[0] = 32'h0;
    @(negedge clk);
    start[0] = 1'b0; mode[0] = 1'bx; addr[0] = 'x; wdata[0] = 'x;
    quiet(0, "dropped strobes", 5);
    issue(0, RD, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0);
    await_done(0, "rd after drop", t0);

    // Out-of-range write aliases word 0 in the low bits but must not land.
    issue(0, WR, 32'h0000_0000, 32'hCAFE_F00D, 32'd0, 1'b0);
    await_done(0, "wr 0x0", t0);
    issue(0, WR, 32'h0000_0400, 32'h1234_5678, 32'd0, 1'b1);
    await_done(0, "wr oor", t0);
    issue(0, RD, 32'h0000_0000, 32'd0, 32'hCAFE_F00D, 1'b0);
    await_done(0, "rd 0x0", t0);
    issue(0, RD, 32'h0000_0400, 32'd0, 32'd0, 1'b1);
    await_done(0, "rd oor", t0);

    // Reset one cycle after a write strobe kills the write.
    issue(0, WR, 32'h0000_0020, 32'h1111_2222, 32'd0, 1'b0);
    await_done(0, "wr 0x20", t0);
    strobe(0, WR, 32'h0000_0020, 32'hA5A5_A5A5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    quiet(0, "reset mid write", 5);
    issue(0, RD, 32'h0000_0020, 32'd0, 32'h1111_2222, 1'b0);
    await_done(0, "rd 0x20", t0);

    // A strobe coinciding with reset is lost.
    rst = 1'b1;
    start[0] = 1'b1; mode[0] = WR; addr[0] = 32'h0000_0020; wdata[0] = 32'h5555_AAAA;
    @(negedge clk);
    rst = 1'b0;
    start[0] = 1'b0; mode[0] = 1'bx; addr[0] = 'x; wdata[0] = 'x;
    quiet(0, "strobe in reset", 5);
    issue(0, RD, 32'h0000_0020, 32'd0, 32'h1111_2222, 1'b0);
    await_done(0, "rd 0x20 again", t0);

    // Zero-wait build: back-to-back, one transaction every two cycles.
    issue(1, WR, 32'h0000_0030, 32'h0BAD_CAFE, 32'd0, 1'b0);
    await_done(1, "w0 wr 0x30", t0);
    issue(1, RD, 32'h0000_0030, 32'd0, 32'h0BAD_CAFE, 1'b0);
    await_done(1, "w0 rd 0x30", t1);
    issue(1, RD, 32'h0000_0031, 32'd0, 32'h0BAD_CAFE, 1'b0);
    await_done(1, "w0 rd 0x31", t2);
    check("w0 spacing 1", t1 - t0, 32'd2);
    check("w0 spacing 2", t2 - t1, 32'd2);
    check("scoreboard drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
